// File: rtl/frame_buf_reader_if.sv
// rtl/frame_buf_reader_if.sv - frame buffer read port and output pixel stream bundle
interface frame_buf_reader_if #(
    parameter int AW = 20
);
    logic          Buffer1Full;
    logic          Buffer2Full;
    logic [7:0]    R1;
    logic [7:0]    G1;
    logic [7:0]    B1;
    logic [7:0]    R2;
    logic [7:0]    G2;
    logic [7:0]    B2;
    logic          RE1;
    logic          RE2;
    logic [AW-1:0] RdAddr;
    logic          Buf1Empty;
    logic          Buf2Empty;
    logic [7:0]    PixR;
    logic [7:0]    PixG;
    logic [7:0]    PixB;
    logic          PixValid;
    logic          PixReady;
    logic          FrameStart;
    logic          ActiveBuf;

    modport master (
        input  Buffer1Full, Buffer2Full, R1, G1, B1, R2, G2, B2, PixReady,
        output RE1, RE2, RdAddr, Buf1Empty, Buf2Empty,
               PixR, PixG, PixB, PixValid, FrameStart, ActiveBuf
    );

    modport slave (
        output Buffer1Full, Buffer2Full, R1, G1, B1, R2, G2, B2, PixReady,
        input  RE1, RE2, RdAddr, Buf1Empty, Buf2Empty,
               PixR, PixG, PixB, PixValid, FrameStart, ActiveBuf
    );
endinterface

// File: rtl/frame_buf_reader.sv
// rtl/frame_buf_reader.sv - ping-pong frame buffer read controller with two-stage pixel pipeline
module frame_buf_reader #(
    parameter int DEPTH = 10000,
    parameter int AW    = 20
) (
    input  logic               clk,
    input  logic               reset,
    frame_buf_reader_if.master bus
);
    typedef enum logic [1:0] {
        WAIT_FULL = 2'd0,
        READ      = 2'd1,
        DRAIN     = 2'd2,
        SWITCH    = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic          active_q, active_d;
    logic          empty1_q, empty1_d;
    logic          empty2_q, empty2_d;
    logic          arm1_q, arm1_d;
    logic          arm2_q, arm2_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pending_q, pending_d;
    logic          s1_first_q, s1_first_d;
    logic          pix_valid_q, pix_valid_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    pix_r_q, pix_r_d;
    logic [7:0]    pix_g_q, pix_g_d;
    logic [7:0]    pix_b_q, pix_b_d;

    logic          sel_full;
    logic          sel_arm;
    logic          xfer;
    logic          issue;

    // Handshake decode: stage-1 to stage-2 move, and whether a new read fits behind it
    always_comb begin
        sel_full = active_q ? bus.Buffer2Full : bus.Buffer1Full;
        sel_arm  = active_q ? arm2_q : arm1_q;
        xfer     = pending_q && (!pix_valid_q || bus.PixReady);
        issue    = (state_q == READ) && (!pending_q || xfer);
    end

    // Frame sequencing: arming, buffer ownership, read address counter
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        empty1_d = empty1_q;
        empty2_d = empty2_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        // A full flag only counts once it has been seen low while the buffer was ours to give away
        arm1_d   = arm1_q || (!bus.Buffer1Full && empty1_q);
        arm2_d   = arm2_q || (!bus.Buffer2Full && empty2_q);
        case (state_q)
            WAIT_FULL: begin
                if (sel_full && sel_arm) begin
                    state_d = READ;
                    cnt_d   = '0;
                    if (active_q) begin
                        empty2_d = 1'b0;
                        arm2_d   = 1'b0;
                    end else begin
                        empty1_d = 1'b0;
                        arm1_d   = 1'b0;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = cnt_q;
                    cnt_d  = cnt_q + AW'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pending_q && (!pix_valid_q || bus.PixReady)) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                if (active_q) begin
                    empty2_d = 1'b1;
                end else begin
                    empty1_d = 1'b1;
                end
                active_d = !active_q;
                state_d  = WAIT_FULL;
            end
            default: state_d = WAIT_FULL;
        endcase
    end

    // Pixel pipeline: pending tracks the buffer output register, Pix* is the output register
    always_comb begin
        pending_d     = issue ? 1'b1 : (xfer ? 1'b0 : pending_q);
        s1_first_d    = issue ? (cnt_q == '0) : s1_first_q;
        pix_valid_d   = xfer ? 1'b1 : (bus.PixReady ? 1'b0 : pix_valid_q);
        frame_start_d = xfer ? s1_first_q : (bus.PixReady ? 1'b0 : frame_start_q);
        pix_r_d       = pix_r_q;
        pix_g_d       = pix_g_q;
        pix_b_d       = pix_b_q;
        if (xfer) begin
            pix_r_d = active_q ? bus.R2 : bus.R1;
            pix_g_d = active_q ? bus.G2 : bus.G1;
            pix_b_d = active_q ? bus.B2 : bus.B1;
        end
    end

    // State registers with asynchronous abort on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_FULL;
            active_q      <= 1'b0;
            empty1_q      <= 1'b1;
            empty2_q      <= 1'b1;
            arm1_q        <= 1'b0;
            arm2_q        <= 1'b0;
            cnt_q         <= '0;
            addr_q        <= '0;
            pending_q     <= 1'b0;
            s1_first_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            empty1_q      <= empty1_d;
            empty2_q      <= empty2_d;
            arm1_q        <= arm1_d;
            arm2_q        <= arm2_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            pending_q     <= pending_d;
            s1_first_q    <= s1_first_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
        end
    end

    assign bus.RE1        = issue && !active_q;
    assign bus.RE2        = issue && active_q;
    assign bus.RdAddr     = issue ? cnt_q : addr_q;
    assign bus.Buf1Empty  = empty1_q;
    assign bus.Buf2Empty  = empty2_q;
    assign bus.PixR       = pix_r_q;
    assign bus.PixG       = pix_g_q;
    assign bus.PixB       = pix_b_q;
    assign bus.PixValid   = pix_valid_q;
    assign bus.FrameStart = frame_start_q;
    assign bus.ActiveBuf  = active_q;
endmodule

// File: tb/tb_frame_buf_reader.sv
// tb/tb_frame_buf_reader.sv - self-checking bench for frame_buf_reader
module tb_frame_buf_reader;
    localparam int DEPTH = 10000;
    localparam int AW    = 20;

    logic clk;
    logic reset;
    bit   rdy_mode;
    int   total;
    int   bad;

    frame_buf_reader_if #(.AW(AW)) bif ();

    frame_buf_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stored word for buffer b at address a; R=[7:0], G=[15:8], B=[23:16]
    function automatic logic [23:0] word(input logic b, input int a);
        return 24'(a * 3) + 24'h010203 + (b ? 24'h800000 : 24'h000000);
    endfunction

    // Buffer models: registered read data, held while RE is low
    always @(posedge clk) begin
        if (bif.RE1) {bif.B1, bif.G1, bif.R1} <= word(1'b0, int'(bif.RdAddr));
        if (bif.RE2) {bif.B2, bif.G2, bif.R2} <= word(1'b1, int'(bif.RdAddr));
    end

    // Downstream ready: always high or a coin flip per cycle
    initial begin
        bif.PixReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bif.PixReady = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model: expected read sequence and pixel sequence across alternating buffers
    int          exp_idx  = 0;
    logic        exp_buf  = 1'b0;
    int          rd_idx   = 0;
    logic        rd_buf   = 1'b0;
    int          inflight = 0;
    logic        hold     = 1'b0;
    logic [24:0] held     = '0;
    logic [23:0] last_pix0 = '0;

    always @(negedge clk) begin
        logic xf;
        logic is;
        if (reset) begin
            exp_idx = 0; exp_buf = 1'b0; rd_idx = 0; rd_buf = 1'b0; inflight = 0; hold = 1'b0;
        end else begin
            xf = bif.PixValid && bif.PixReady;
            is = bif.RE1 || bif.RE2;
            chk("re_exclusive", 32'(bif.RE1 && bif.RE2), 32'd0);
            if (hold) begin
                chk("stall_valid", 32'(bif.PixValid), 32'd1);
                chk("stall_data", 32'({bif.FrameStart, bif.PixB, bif.PixG, bif.PixR}), 32'(held));
            end
            if (is) begin
                chk("re_buffer", 32'(bif.RE2), 32'(rd_buf));
                chk("re_activebuf", 32'(bif.ActiveBuf), 32'(rd_buf));
                chk("rd_addr", 32'(bif.RdAddr), 32'(rd_idx));
                chk("rd_slot_free", 32'((inflight - int'(xf)) < 2), 32'd1);
                rd_idx++;
                if (rd_idx == DEPTH) begin rd_idx = 0; rd_buf = ~rd_buf; end
                inflight++;
            end
            if (xf) begin
                chk("pixel", 32'({bif.PixB, bif.PixG, bif.PixR}), 32'(word(exp_buf, exp_idx)));
                chk("frame_start", 32'(bif.FrameStart), 32'(exp_idx == 0));
                chk("pix_activebuf", 32'(bif.ActiveBuf), 32'(exp_buf));
                if (!exp_buf && exp_idx == DEPTH - 1) last_pix0 = {bif.PixB, bif.PixG, bif.PixR};
                exp_idx++;
                if (exp_idx == DEPTH) begin exp_idx = 0; exp_buf = ~exp_buf; end
                inflight--;
            end
            hold = bif.PixValid && !bif.PixReady;
            held = {bif.FrameStart, bif.PixB, bif.PixG, bif.PixR};
        end
    end

    initial begin
        int n;
        int k;
        int re_cnt;
        total = 0;
        bad = 0;
        rdy_mode = 1'b0;
        reset = 1'b1;
        bif.Buffer1Full = 1'b0;
        bif.Buffer2Full = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_buf1empty", 32'(bif.Buf1Empty), 32'd1);
        chk("rst_buf2empty", 32'(bif.Buf2Empty), 32'd1);
        chk("rst_re1", 32'(bif.RE1), 32'd0);
        chk("rst_re2", 32'(bif.RE2), 32'd0);
        chk("rst_pixvalid", 32'(bif.PixValid), 32'd0);
        chk("rst_rdaddr", 32'(bif.RdAddr), 32'd0);
        chk("rst_activebuf", 32'(bif.ActiveBuf), 32'd0);

        // Frame 1: buffer 1, ready held high; buffer 2 fills mid-frame
        bif.Buffer1Full = 1'b1;
        n = 0;
        while (bif.Buf1Empty !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        chk("f1_start", 32'(bif.Buf1Empty), 32'd0);
        chk("f1_first_addr", 32'(bif.RdAddr), 32'd0);
        re_cnt = 0;
        k = 0;
        while (k < 3 * DEPTH) begin
            if (k == 1) chk("f1_no_pix_yet", 32'(bif.PixValid), 32'd0);
            if (k == 2) begin
                chk("f1_pix0_valid", 32'(bif.PixValid), 32'd1);
                chk("f1_pix0_fs", 32'(bif.FrameStart), 32'd1);
                chk("f1_pix0_r", 32'(bif.PixR), 32'h03);
                chk("f1_pix0_g", 32'(bif.PixG), 32'h02);
                chk("f1_pix0_b", 32'(bif.PixB), 32'h01);
            end
            if (k == 3) chk("f1_pix1_fs", 32'(bif.FrameStart), 32'd0);
            if (k == 3000) bif.Buffer2Full = 1'b1;
            if (k == 5000) begin
                chk("f1_mid_buf1empty", 32'(bif.Buf1Empty), 32'd0);
                chk("f1_mid_buf2empty", 32'(bif.Buf2Empty), 32'd1);
            end
            if (bif.RE1 !== 1'b1) break;
            re_cnt++;
            @(negedge clk);
            k++;
        end
        chk("f1_re1_run", 32'(re_cnt), 32'(DEPTH));
        n = 0;
        while (bif.ActiveBuf !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("f1_switch_active", 32'(bif.ActiveBuf), 32'd1);
        chk("f1_switch_buf1empty", 32'(bif.Buf1Empty), 32'd1);

        // Frame 2: buffer 2 starts at once, random ready
        rdy_mode = 1'b1;
        @(negedge clk);
        chk("f2_start", 32'(bif.Buf2Empty), 32'd0);
        chk("f2_re2", 32'(bif.RE2), 32'd1);
        chk("f2_first_addr", 32'(bif.RdAddr), 32'd0);
        n = 0;
        while (bif.ActiveBuf !== 1'b0 && n < 6 * DEPTH) begin @(negedge clk); n++; end
        chk("f2_switch_active", 32'(bif.ActiveBuf), 32'd0);
        chk("f2_switch_buf2empty", 32'(bif.Buf2Empty), 32'd1);
        chk("f1_last_pixel", 32'(last_pix0), 32'h017730);

        // Stale full on buffer 1 must not start a frame
        re_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bif.RE1 || bif.RE2) re_cnt++;
        end
        chk("stale_full_no_read", 32'(re_cnt), 32'd0);
        chk("stale_full_buf1empty", 32'(bif.Buf1Empty), 32'd1);

        // Frame 3: re-armed by a low pulse, aborted by reset at pixel 5000
        rdy_mode = 1'b0;
        bif.Buffer1Full = 1'b0;
        @(negedge clk);
        bif.Buffer1Full = 1'b1;
        n = 0;
        while (bif.Buf1Empty !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        chk("f3_start", 32'(bif.Buf1Empty), 32'd0);
        chk("f3_first_addr", 32'(bif.RdAddr), 32'd0);
        n = 0;
        while (exp_idx < 5000 && n < 3 * DEPTH) begin @(negedge clk); n++; end
        chk("f3_reached_5000", 32'(exp_idx >= 5000), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_re1", 32'(bif.RE1), 32'd0);
        chk("arst_re2", 32'(bif.RE2), 32'd0);
        chk("arst_rdaddr", 32'(bif.RdAddr), 32'd0);
        chk("arst_buf1empty", 32'(bif.Buf1Empty), 32'd1);
        chk("arst_buf2empty", 32'(bif.Buf2Empty), 32'd1);
        chk("arst_pixvalid", 32'(bif.PixValid), 32'd0);
        chk("arst_pix", 32'({bif.PixB, bif.PixG, bif.PixR}), 32'd0);
        chk("arst_framestart", 32'(bif.FrameStart), 32'd0);
        chk("arst_activebuf", 32'(bif.ActiveBuf), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // After reset, the still-high full flags are not trusted
        re_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bif.RE1 || bif.RE2) re_cnt++;
        end
        chk("post_rst_no_read", 32'(re_cnt), 32'd0);

        // Frame 4: fresh armed full restarts at buffer 1 address 0, random ready
        rdy_mode = 1'b1;
        bif.Buffer1Full = 1'b0;
        @(negedge clk);
        bif.Buffer1Full = 1'b1;
        n = 0;
        while (bif.Buf1Empty !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        chk("f4_start", 32'(bif.Buf1Empty), 32'd0);
        chk("f4_re1", 32'(bif.RE1), 32'd1);
        chk("f4_first_addr", 32'(bif.RdAddr), 32'd0);
        chk("f4_activebuf", 32'(bif.ActiveBuf), 32'd0);
        n = 0;
        while (bif.ActiveBuf !== 1'b1 && n < 6 * DEPTH) begin @(negedge clk); n++; end
        chk("f4_switch_active", 32'(bif.ActiveBuf), 32'd1);
        chk("f4_all_pixels", 32'({exp_buf, 31'(exp_idx)}), 32'h80000000);
        chk("f4_drained", 32'(inflight), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_buf_reader.md
Name: frame_buf_reader

Overview:
- Read-side controller for the two ping-pong frame buffers (Buf1/Buf2, DEPTH pixels of 24-bit RGB each).
- Waits for a buffer to report full, then issues RE/address reads 0..DEPTH-1 and streams the returned R/G/B out on a valid/ready pixel interface.
- Hands the buffer back to the writer via BufxEmpty, then switches to the other buffer.
- Sits between the frame buffers and the display timing/output stage.

Parameters:
- DEPTH, 10000, pixels per buffer; last address is DEPTH-1.
- AW, 20, read address width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Buffer1Full  in  1  buffer 1 has been written up to address DEPTH-1.
- Buffer2Full  in  1  buffer 2 has been written up to address DEPTH-1.
- R1, G1, B1  in  8 each  buffer 1 registered read data, valid the cycle after RE1.
- R2, G2, B2  in  8 each  buffer 2 registered read data, valid the cycle after RE2.
- RE1  out  1  read enable, buffer 1.
- RE2  out  1  read enable, buffer 2.
- RdAddr  out  AW  shared read address to both buffers.
- Buf1Empty  out  1  buffer 1 is free for the writer.
- Buf2Empty  out  1  buffer 2 is free for the writer.
- PixR, PixG, PixB  out  8 each  output pixel.
- PixValid  out  1  output pixel valid.
- PixReady  in  1  downstream accepts the pixel.
- FrameStart  out  1  high with PixValid on pixel 0 of each buffer.
- ActiveBuf  out  1  0 = buffer 1 selected, 1 = buffer 2 selected.

Behaviour:
- Reset values: RE1=RE2=0, RdAddr=0, Buf1Empty=Buf2Empty=1, PixValid=0, PixR/G/B=0, FrameStart=0, ActiveBuf=0, state WAIT_FULL, arm1=arm2=0, internal pending=0.
- Reset mid-frame aborts everything; the next frame restarts at buffer 1, address 0.
- Arming rule: armx is set when BufferxFull is sampled 0 while BufxEmpty=1. BufferxFull is honoured only when armx=1. This rejects a stale full flag. armx clears on entry to READ for that buffer.
- FSM states:
  - WAIT_FULL: when the selected buffer has Full=1 and arm=1 → READ. Drive BufxEmpty=0 for that buffer from the same edge. Set counter=0.
  - READ: issue reads at addresses 0..DEPTH-1 (rule below). The edge that issues address DEPTH-1 → DRAIN.
  - DRAIN: no reads. Wait until pending=0 and the output stage is empty or consumed → SWITCH.
  - SWITCH (1 cycle): set the drained buffer's BufxEmpty=1, toggle ActiveBuf → WAIT_FULL.
- Pipeline: buffer output register = stage 1 (pending flag); Pix* register = stage 2.
  - Stage 2 loads from the selected buffer's R/G/B when pending=1 and (PixValid=0 or PixReady=1).
  - A read (REx=1, RdAddr=counter, counter++) is issued in READ when pending=0, or pending is being moved to stage 2 in the same cycle.
  - pending is set by an issue and cleared by a transfer; issue and transfer in the same cycle leave it at 1.
  - The buffer holds its output while REx=0, so stall is lossless.
- Throughput: 1 pixel/clk with PixReady held high. First PixValid appears 2 clks after the READ entry edge.
- Only the selected buffer's RE may be high; RE1 and RE2 are never both 1. RdAddr holds its value when no read is issued.
- Pixel handshake: Pix* and PixValid are held stable while PixValid=1 and PixReady=0. A transfer occurs on PixValid & PixReady.
- FrameStart = 1 exactly while stage 2 holds address 0's pixel.
- Width/wrap: counter is AW bits and is never compared beyond DEPTH-1. No wrap within a frame; the counter resets to 0 on READ entry.
- Simultaneous events: the other buffer becoming full during READ is ignored until WAIT_FULL. Full=1 on the same edge as SWITCH is taken on the next WAIT_FULL cycle.

Test Plan:
- Reset → Buf1Empty=Buf2Empty=1, RE1=RE2=0, PixValid=0, RdAddr=0.
- Buffer1Full 0→1, PixReady=1 → RE1 on 10000 consecutive clks with RdAddr 0..9999; pixel N = stored word N split R=[7:0], G=[15:8], B=[23:16]; FrameStart on pixel 0 only; Buf1Empty=0 through the frame, 1 after SWITCH; ActiveBuf=1.
- Random PixReady (~50%) → no pixel dropped or duplicated across 10000 pixels; Pix* stable while stalled; RE issued only when a slot frees.
- Buffer1Full held at 1 (never seen low) after SWITCH back to buffer 1 → controller stays in WAIT_FULL; after a 0 then 1 pulse it starts reading.
- Buffer2Full rises during a buffer-1 read → no RE2 until buffer-1 SWITCH; then buffer 2 streams immediately from address 0.
- Assert reset at pixel 5000 → outputs return to reset values asynchronously; after release, reading restarts at buffer 1 address 0 only after a fresh armed Buffer1Full.
